// File: rtl/mycpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mycpu_div_pkg
// Description : Shared constants for the iterative EXE-stage divider.
// Revision    : 1.0 - initial release
// ============================================================================
package mycpu_div_pkg;

  // Default operand width; one quotient bit is produced per iteration
  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = DIV_DATA_W;

  // Controller state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Quotient returned for a zero divisor (both signed and unsigned modes)
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_Q = '1;

endpackage
`default_nettype wire

// File: rtl/mycpu_div_if.sv
`default_nettype none
// ============================================================================
// Module      : mycpu_div_if
// Description : Request/result handshake bundle between EXE stage and divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface mycpu_div_if
  import mycpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) ();

  logic              div_valid;
  logic              div_ready;
  logic              div_signed;
  logic [DATA_W-1:0] div_src1;
  logic [DATA_W-1:0] div_src2;
  logic              div_cancel;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  // Pipeline side: issues requests, consumes results
  modport master (
    output div_valid, div_signed, div_src1, div_src2, div_cancel, res_ready,
    input  div_ready, res_valid, div_quotient, div_remainder
  );

  // Divider side
  modport slave (
    input  div_valid, div_signed, div_src1, div_src2, div_cancel, res_ready,
    output div_ready, res_valid, div_quotient, div_remainder
  );

endinterface
`default_nettype wire

// File: rtl/mycpu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import mycpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W:0]   partial,   // shifted partial remainder, one bit wider
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  // Trial subtraction: keep the difference only when it does not borrow.
  // When it does not borrow the true difference is below the divisor, so
  // modulo-2^DATA_W arithmetic on the low bits is exact.
  always_comb begin
    q_bit    = (partial >= {1'b0, divisor});
    rem_next = q_bit ? (partial[DATA_W-1:0] - divisor) : partial[DATA_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mycpu_div.sv
`default_nettype none
// ============================================================================
// Module      : mycpu_div
// Description : Multi-cycle restoring divider for div.w/div.wu/mod.w/mod.wu.
//               One quotient bit per cycle, valid/ready on both sides,
//               pipeline flush via div_cancel.
// Revision    : 1.0 - initial release
// ============================================================================
module mycpu_div
  import mycpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic      clk,
  input  logic      resetn,
  mycpu_div_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ZERO_Q  = {DATA_W{DIV_ZERO_Q[0]}};

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic              accept;
  logic              src2_zero;
  logic [DATA_W-1:0] src1_load;
  logic [DATA_W-1:0] src2_load;
  logic [DATA_W-1:0] rem_next;
  logic              q_bit;

  assign accept    = (state == S_IDLE) & bus.div_valid & ~bus.div_cancel;
  assign src2_zero = (bus.div_src2 == '0);

  // Operand conditioning: magnitudes for signed requests. With a zero divisor
  // the raw dividend is loaded instead; dividing by zero then shifts it
  // unchanged into the remainder, which is exactly the required result.
  always_comb begin
    src1_load = bus.div_src1;
    src2_load = bus.div_src2;
    if (bus.div_signed && bus.div_src1[DATA_W-1] && !src2_zero) begin
      src1_load = -bus.div_src1;
    end
    if (bus.div_signed && bus.div_src2[DATA_W-1]) begin
      src2_load = -bus.div_src2;
    end
  end

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .partial  ({rem, quo[DATA_W-1]}),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Controller state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a flush returns to IDLE from anywhere
  always_comb begin
    state_next = state;
    if (bus.div_cancel) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.div_valid)              state_next = S_BUSY;
        S_BUSY:  if (cnt == LAST_CNT)            state_next = S_DONE;
        S_DONE:  if (bus.res_ready)              state_next = S_IDLE;
        default:                                 state_next = S_IDLE;
      endcase
    end
  end

  // Handshake outputs and sign fix-up of the held iteration result
  always_comb begin
    bus.div_ready     = (state == S_IDLE);
    bus.res_valid     = (state == S_DONE);
    bus.div_quotient  = neg_q ? -quo : quo;
    bus.div_remainder = neg_r ? -rem : rem;
    if (div_zero) begin
      bus.div_quotient  = ZERO_Q;
      bus.div_remainder = rem;
    end
  end

  // Datapath: load operands on accept, then one restoring step per BUSY cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= src1_load;
      divisor  <= src2_load;
      neg_q    <= bus.div_signed & (bus.div_src1[DATA_W-1] ^ bus.div_src2[DATA_W-1]);
      neg_r    <= bus.div_signed & bus.div_src1[DATA_W-1];
      div_zero <= src2_zero;
    end else if (state == S_BUSY) begin
      cnt <= cnt + 1'b1;
      rem <= rem_next;
      quo <= {quo[DATA_W-2:0], q_bit};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mycpu_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_mycpu_div
// Description : Self-checking bench for mycpu_div with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mycpu_div;
  import mycpu_div_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  mycpu_div_if #(.DATA_W(32)) bus ();

  mycpu_div #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
  } vec_t;

  // Reference: 64-bit arithmetic, truncating division, zero-divisor rule
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  // Issue one request and wait for res_valid; leaves the block in DONE
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    int guard;
    guard = 0;
    while (bus.div_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.div_valid  = 1'b1;
    bus.div_signed = sgn;
    bus.div_src1   = a;
    bus.div_src2   = b;
    @(posedge clk); #1;
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'($urandom);
    bus.div_src1   = $urandom;
    bus.div_src2   = $urandom;
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    q = bus.div_quotient;
    r = bus.div_remainder;
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.div_ready); else passes++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); else passes++;
    checks++; if (bus.div_quotient !== 32'd0) $display("FAIL reset_quotient: got %h expected 0", bus.div_quotient); else passes++;
    checks++; if (bus.div_remainder !== 32'd0) $display("FAIL reset_remainder: got %h expected 0", bus.div_remainder); else passes++;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_directed();
    vec_t        tbl[8];
    logic [31:0] q, r;
    int          lat;
    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[2] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    tbl[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    tbl[4] = '{1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5};
    tbl[5] = '{1'b1, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFB};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0};
    tbl[7] = '{1'b0, 32'd3,         32'd10,         32'd0,          32'd3};
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, q, r, lat);
      checks++; if (lat !== DIV_ITER) $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, DIV_ITER); else passes++;
      checks++; if (q !== tbl[i].eq) $display("FAIL dir%0d_quotient: got %h expected %h", i, q, tbl[i].eq); else passes++;
      checks++; if (r !== tbl[i].er) $display("FAIL dir%0d_remainder: got %h expected %h", i, r, tbl[i].er); else passes++;
      handshake();
      checks++; if (bus.div_ready !== 1'b1 || bus.res_valid !== 1'b0)
        $display("FAIL dir%0d_idle: got ready=%b valid=%b expected ready=1 valid=0", i, bus.div_ready, bus.res_valid);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    int          lat;
    bit          sgn;
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(7, 0))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(15, 1));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model(sgn, a, b, eq, er);
      run_op(sgn, a, b, q, r, lat);
      checks++; if (lat !== DIV_ITER) $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, DIV_ITER); else passes++;
      checks++; if (q !== eq) $display("FAIL rnd%0d_quotient s=%b a=%h b=%h: got %h expected %h", i, sgn, a, b, q, eq); else passes++;
      checks++; if (r !== er) $display("FAIL rnd%0d_remainder s=%b a=%h b=%h: got %h expected %h", i, sgn, a, b, r, er); else passes++;
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q, r;
    int          lat;
    run_op(1'b0, 32'd1000, 32'd33, q, r, lat);
    checks++; if (q !== 32'd30 || r !== 32'd10) $display("FAIL bp_result: got q=%h r=%h expected q=1e r=a", q, r); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.div_ready !== 1'b0 ||
          bus.div_quotient !== 32'd30 || bus.div_remainder !== 32'd10)
        $display("FAIL bp_hold%0d: got valid=%b ready=%b q=%h r=%h expected valid=1 ready=0 q=1e r=a",
                 i, bus.res_valid, bus.div_ready, bus.div_quotient, bus.div_remainder);
      else passes++;
    end
    handshake();
    checks++; if (bus.div_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", bus.div_ready, bus.res_valid);
    else passes++;
  endtask

  task automatic test_cancel();
    logic [31:0] q, r;
    int          lat;
    bit          seen;
    // Flush in the middle of an operation
    bus.div_valid = 1'b1; bus.div_signed = 1'b0; bus.div_src1 = 32'd77; bus.div_src2 = 32'd5;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.div_cancel = 1'b1;
    @(posedge clk); #1;
    bus.div_cancel = 1'b0;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL cancel_ready: got %b expected 1", bus.div_ready); else passes++;
    seen = 1'b0;
    repeat (40) begin
      if (bus.res_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL cancel_no_result: got %b expected 0", seen); else passes++;
    run_op(1'b0, 32'd9, 32'd3, q, r, lat);
    checks++; if (q !== 32'd3 || r !== 32'd0 || lat !== DIV_ITER)
      $display("FAIL cancel_next_op: got q=%h r=%h lat=%0d expected q=3 r=0 lat=%0d", q, r, lat, DIV_ITER);
    else passes++;
    // Cancel wins over a result handshake in the same cycle
    bus.div_cancel = 1'b1; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.div_cancel = 1'b0; bus.res_ready = 1'b0;
    checks++; if (bus.div_ready !== 1'b1 || bus.res_valid !== 1'b0)
      $display("FAIL cancel_done: got ready=%b valid=%b expected ready=1 valid=0", bus.div_ready, bus.res_valid);
    else passes++;
    // A request presented together with cancel is not accepted
    bus.div_valid = 1'b1; bus.div_cancel = 1'b1; bus.div_src1 = 32'd8; bus.div_src2 = 32'd2;
    @(posedge clk); #1;
    bus.div_valid = 1'b0; bus.div_cancel = 1'b0;
    checks++; if (bus.div_ready !== 1'b1) $display("FAIL cancel_blocks_accept: got ready=%b expected 1", bus.div_ready); else passes++;
    seen = 1'b0;
    repeat (40) begin
      if (bus.res_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL cancel_blocks_result: got %b expected 0", seen); else passes++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] q, r;
    int          lat;
    bit          seen;
    bus.div_valid = 1'b1; bus.div_signed = 1'b0; bus.div_src1 = 32'd50; bus.div_src2 = 32'd3;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.div_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.div_quotient !== 32'd0 || bus.div_remainder !== 32'd0)
      $display("FAIL midop_reset: got ready=%b valid=%b q=%h r=%h expected ready=1 valid=0 q=0 r=0",
               bus.div_ready, bus.res_valid, bus.div_quotient, bus.div_remainder);
    else passes++;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      if (bus.res_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midop_stale: got %b expected 0", seen); else passes++;
    run_op(1'b0, 32'd50, 32'd3, q, r, lat);
    checks++; if (q !== 32'd16 || r !== 32'd2 || lat !== DIV_ITER)
      $display("FAIL midop_next_op: got q=%h r=%h lat=%0d expected q=10 r=2 lat=%0d", q, r, lat, DIV_ITER);
    else passes++;
    handshake();
  endtask

  initial begin
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_src1   = '0;
    bus.div_src2   = '0;
    bus.div_cancel = 1'b0;
    bus.res_ready  = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_cancel();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mycpu_div.md
Name: mycpu_div

Overview:
- Multi-cycle iterative 32-bit integer divider for the EXE stage of the LoongArch myCPU pipeline.
- Complements the single-cycle ALU: the ALU completes in one cycle, this block stalls the pipeline instead.
- Executes div.w, div.wu, mod.w and mod.wu as a radix-2 restoring divider, one quotient bit per cycle.
- Uses a valid/ready handshake on both sides and honours a pipeline flush (cancel).

Parameters:
- DATA_W, 32: operand width; must be a power of two. Iteration count = DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- div_valid  in  1  request valid.
- div_ready  out  1  request accepted when div_valid & div_ready.
- div_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned.
- div_src1  in  DATA_W  dividend.
- div_src2  in  DATA_W  divisor.
- div_cancel  in  1  flush: abort any operation, discard its result.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer takes result when res_valid & res_ready.
- div_quotient  out  DATA_W  quotient.
- div_remainder  out  DATA_W  remainder.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, counter 0, res_valid 0, div_quotient 0, div_remainder 0, div_ready 1.
- States:
  - IDLE: div_ready = 1. Accept on div_valid & ~div_cancel → BUSY. Operands latched; magnitudes taken when div_signed; sign flags and zero-divisor flag stored.
  - BUSY: div_ready = 0. One restoring step per cycle: shift {rem, quo} left 1, trial-subtract divisor, set quotient bit if no borrow. 5-bit counter runs 0..31; after step 31 → DONE.
  - DONE: res_valid = 1; results held stable while res_ready = 0; on res_ready → IDLE.
- Latency: accept at the edge ending cycle T; BUSY during T+1..T+32; res_valid first high in cycle T+33.
- Earliest re-accept: div_ready high in the cycle after the result handshake. No overlap between operations.
- Signed fix-up:
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Truncation toward zero.
- Divide by zero (both modes): quotient = all ones, remainder = div_src1 unchanged. Fix-up is bypassed; the iteration still runs the full 32 cycles, so latency is constant.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0, with no exception.
- div_cancel:
  - In any state, forces IDLE at the next edge and clears res_valid.
  - Takes priority over div_valid in the same cycle; a request is not accepted while cancel is high.
  - In DONE with res_ready high in the same cycle, cancel wins; the consumer must ignore the result.
- Operand inputs are sampled only at acceptance; later changes have no effect.
- div_quotient/div_remainder are don't-care outside DONE but must not toggle while res_valid is high.
- Reset asserted mid-operation: immediate return to the reset values; no result is produced.

Decomposition:
- Shared package mycpu_div_pkg:
  - State encoding localparams: S_IDLE, S_BUSY, S_DONE.
  - DIV_ITER = DATA_W.
  - Divide-by-zero quotient constant (all ones).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in mycpu_div.

Test Plan:
- Unsigned 100/7: div_signed=0, src1=100, src2=7 → res_valid at T+33; quotient 14, remainder 2; res_ready=1 returns the block to IDLE, div_ready=1 at T+34.
- Signed -7/2: src1=0xFFFFFFF9, src2=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7/-2 → quotient 0xFFFFFFFD, remainder 1.
- Corner values:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Unsigned 5/0 → quotient 0xFFFFFFFF, remainder 5, still at T+33.
- Flush: accept at T, assert div_cancel in cycle T+10 → res_valid never rises; div_ready=1 at T+11. A new 9/3 request then returns quotient 3, remainder 0.
- Backpressure: res_ready held 0 for 5 cycles after res_valid → outputs and res_valid stable, div_ready=0; handshake on cycle 6 → IDLE.
- Reset mid-op: resetn pulsed low at T+15 → res_valid=0, outputs 0, div_ready=1 immediately (asynchronous); no stale result after resetn releases.
